// File: rtl/multi_timer_pkg.sv
// -----------------------------------------------------------------------------
// multi_timer_pkg
//   Shared definitions for the multi-channel timer peripheral:
//   - per-channel register offsets (CTRL / COUNT / VALUE / PRESC)
//   - CTRL bit indices (EN, IE, PEND, MODE)
//   - channel mode encodings (one-shot / periodic)
//   - interrupt levels, the zero read word and the bus write-strobe level
//     inherited from the single-timer peripheral
// -----------------------------------------------------------------------------
package multi_timer_pkg;

  // Register offsets within one channel's 16-byte window.
  localparam logic [3:0] OFF_CTRL  = 4'h0;
  localparam logic [3:0] OFF_COUNT = 4'h4;
  localparam logic [3:0] OFF_VALUE = 4'h8;
  localparam logic [3:0] OFF_PRESC = 4'hC;

  // CTRL register bit positions.
  localparam int CTRL_EN   = 0;
  localparam int CTRL_IE   = 1;
  localparam int CTRL_PEND = 2;
  localparam int CTRL_MODE = 3;

  // Channel mode, stored in CTRL[MODE].
  typedef enum logic {
    MODE_ONESHOT  = 1'b0,
    MODE_PERIODIC = 1'b1
  } mode_e;

  // Levels shared with the previous single-timer peripheral.
  localparam logic        INT_ASSERT   = 1'b1;
  localparam logic        INT_DEASSERT = 1'b0;
  localparam logic [31:0] ZeroWord     = 32'h0000_0000;
  localparam logic        WriteEnable  = 1'b1;

endpackage

// File: rtl/multi_timer_chan.sv
// -----------------------------------------------------------------------------
// multi_timer_chan
//   One timer channel: CTRL / COUNT / VALUE (/ PRESC) registers, optional
//   prescaler, count-up counter and expiry logic.
//
//   Optional feature macro: TIMER_PRESCALER_EN
//     defined   -> PS_W-bit prescaler; the channel ticks once every PRESC+1
//                  enabled cycles, PRESC is read/write at offset 0xC.
//     undefined -> no prescaler logic; the channel ticks every enabled cycle
//                  and offset 0xC reads 0 / ignores writes.
//
//   Ports
//     clk      in   clock, all state on the rising edge
//     rst      in   asynchronous active-high reset
//     wr_en    in   write strobe already decoded for this channel
//     off      in   register offset (shared by write and read)
//     wr_data  in   write data
//     rd_data  out  combinational read data for offset 'off'
//     irq      out  pending & int_en
// -----------------------------------------------------------------------------
module multi_timer_chan
  import multi_timer_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int PS_W  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [3:0]  off,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        irq
);

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic             enable_reg,  enable_next;
  logic             int_en_reg,  int_en_next;
  logic             pending_reg, pending_next;
  mode_e            mode_reg,    mode_next;
  logic [CNT_W-1:0] count_reg,   count_next;
  logic [CNT_W-1:0] value_reg,   value_next;

  logic wr_ctrl;
  logic wr_value;
  logic tick;
  logic expire;

  // Every write-data bit that a register does not use (depends on CNT_W).
  logic unused_wr_data;
  assign unused_wr_data = ^wr_data;

`ifdef TIMER_PRESCALER_EN
  localparam logic [PS_W-1:0] PsOne = PS_W'(1);

  logic [PS_W-1:0] presc_reg,  presc_next;
  logic [PS_W-1:0] ps_cnt_reg, ps_cnt_next;
  logic            wr_presc;
`else
  logic [PS_W-1:0] unused_presc;
  assign unused_presc = '0;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ctrl  = wr_en && (off == OFF_CTRL);
    wr_value = wr_en && (off == OFF_VALUE);

`ifdef TIMER_PRESCALER_EN
    wr_presc = wr_en && (off == OFF_PRESC);
    // '>=' rather than '==' so that shrinking PRESC below the running
    // prescaler count ticks at once instead of wrapping through 2^PS_W.
    tick     = enable_reg && (ps_cnt_reg >= presc_reg);
`else
    tick     = enable_reg;
`endif

    // '>=' makes a VALUE written below COUNT expire on the next tick.
    expire = tick && (count_reg >= value_reg);

    // Counter: a disabled channel is held at zero.
    count_next = count_reg;
    if (!enable_reg) begin
      count_next = '0;
    end else if (expire) begin
      count_next = '0;
    end else if (tick) begin
      count_next = count_reg + CntOne;
    end

    // Pending: an expiry in the same cycle beats a W1C clear.
    pending_next = pending_reg;
    if (expire) begin
      pending_next = 1'b1;
    end else if (wr_ctrl && wr_data[CTRL_PEND]) begin
      pending_next = 1'b0;
    end

    // Enable: a CTRL write always wins over the one-shot self-clear.
    enable_next = enable_reg;
    if (wr_ctrl) begin
      enable_next = wr_data[CTRL_EN];
    end else if (expire && (mode_reg == MODE_ONESHOT)) begin
      enable_next = 1'b0;
    end

    int_en_next = wr_ctrl ? wr_data[CTRL_IE] : int_en_reg;
    mode_next   = wr_ctrl ? mode_e'(wr_data[CTRL_MODE]) : mode_reg;
    value_next  = wr_value ? wr_data[CNT_W-1:0] : value_reg;

`ifdef TIMER_PRESCALER_EN
    presc_next  = wr_presc ? wr_data[PS_W-1:0] : presc_reg;
    ps_cnt_next = ps_cnt_reg;
    if (!enable_reg || tick) begin
      ps_cnt_next = '0;
    end else begin
      ps_cnt_next = ps_cnt_reg + PsOne;
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enable_reg  <= 1'b0;
      int_en_reg  <= 1'b0;
      pending_reg <= 1'b0;
      mode_reg    <= MODE_ONESHOT;
      count_reg   <= '0;
      value_reg   <= '0;
    end else begin
      enable_reg  <= enable_next;
      int_en_reg  <= int_en_next;
      pending_reg <= pending_next;
      mode_reg    <= mode_next;
      count_reg   <= count_next;
      value_reg   <= value_next;
    end
  end

`ifdef TIMER_PRESCALER_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_reg  <= '0;
      ps_cnt_reg <= '0;
    end else begin
      presc_reg  <= presc_next;
      ps_cnt_reg <= ps_cnt_next;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Read mux and interrupt
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_data = ZeroWord;
    case (off)
      OFF_CTRL: begin
        rd_data[CTRL_EN]   = enable_reg;
        rd_data[CTRL_IE]   = int_en_reg;
        rd_data[CTRL_PEND] = pending_reg;
        rd_data[CTRL_MODE] = mode_reg;
      end
      OFF_COUNT: rd_data[CNT_W-1:0] = count_reg;
      OFF_VALUE: rd_data[CNT_W-1:0] = value_reg;
`ifdef TIMER_PRESCALER_EN
      OFF_PRESC: rd_data[PS_W-1:0]  = presc_reg;
`endif
      default:   rd_data = ZeroWord;
    endcase
  end

  assign irq = pending_reg & int_en_reg;

endmodule

// File: rtl/multi_timer.sv
// -----------------------------------------------------------------------------
// multi_timer
//   NUM_CH independent count-up timer channels on the simple peripheral bus
//   (single-cycle writes, combinational reads).
//
//   Optional feature macro: TIMER_PRESCALER_EN (per-channel clock prescaler,
//   see multi_timer_chan).
//
//   Parameters
//     NUM_CH  channel count, 1..16
//     CNT_W   counter / compare width, 8..32
//     PS_W    prescaler width, 1..16 (only used with TIMER_PRESCALER_EN)
//
//   Ports
//     clk        in   clock
//     rst        in   asynchronous active-high reset
//     data_i     in   write data
//     addr_i     in   byte address: [7:4] channel, [3:0] register offset
//     we_i       in   write strobe
//     data_o     out  combinational read data (0 for unmapped addresses)
//     int_sig_o  out  OR of int_vec_o
//     int_vec_o  out  per-channel pending & int_en
// -----------------------------------------------------------------------------
module multi_timer
  import multi_timer_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 32,
  parameter int PS_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       data_i,
  input  logic [31:0]       addr_i,
  input  logic              we_i,
  output logic [31:0]       data_o,
  output logic              int_sig_o,
  output logic [NUM_CH-1:0] int_vec_o
);

  logic [3:0]        ch;
  logic [3:0]        off;
  logic              ch_valid;
  logic [NUM_CH-1:0] chan_we;
  logic [31:0]       chan_rd [NUM_CH];

  // Only the channel and offset fields take part in the decode.
  logic unused_addr;
  assign unused_addr = ^addr_i[31:8];

  assign ch  = addr_i[7:4];
  assign off = addr_i[3:0];

  // Widen to 5 bits so NUM_CH = 16 compares correctly.
  assign ch_valid = ({1'b0, ch} < 5'(NUM_CH));

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
    assign chan_we[gi] = (we_i == WriteEnable) && ch_valid && (ch == 4'(gi));

    multi_timer_chan #(
      .CNT_W (CNT_W),
      .PS_W  (PS_W)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (chan_we[gi]),
      .off     (off),
      .wr_data (data_i),
      .rd_data (chan_rd[gi]),
      .irq     (int_vec_o[gi])
    );
  end

  // Read mux: channels outside NUM_CH read as zero.
  always_comb begin
    data_o = ZeroWord;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_valid && (ch == 4'(i))) begin
        data_o = chan_rd[i];
      end
    end
  end

  assign int_sig_o = (|int_vec_o) ? INT_ASSERT : INT_DEASSERT;

endmodule

// File: tb/tb_multi_timer.sv
// -----------------------------------------------------------------------------
// tb_multi_timer
//   Directed bench for multi_timer. Stimulus pushes the expected value of
//   every observation into a scoreboard queue and raises an event; a separate
//   monitor process pops the queue and compares against the DUT output.
//   A second instance with NUM_CH = 1, CNT_W = 8 shares the bus to check
//   narrow-register behaviour.
// -----------------------------------------------------------------------------
module tb_multi_timer;

  localparam int K_DATA = 0;  // main DUT data_o
  localparam int K_SIG  = 1;  // main DUT int_sig_o
  localparam int K_VEC  = 2;  // main DUT int_vec_o
  localparam int K_D8   = 3;  // narrow DUT data_o

  logic        clk;
  logic        rst;
  logic [31:0] data_i;
  logic [31:0] addr_i;
  logic        we_i;
  logic [31:0] data_o;
  logic        int_sig_o;
  logic [1:0]  int_vec_o;
  logic [31:0] data_o8;
  logic        int_sig8;
  logic [0:0]  int_vec8;

  multi_timer #(.NUM_CH(2), .CNT_W(32), .PS_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .data_i    (data_i),
    .addr_i    (addr_i),
    .we_i      (we_i),
    .data_o    (data_o),
    .int_sig_o (int_sig_o),
    .int_vec_o (int_vec_o)
  );

  multi_timer #(.NUM_CH(1), .CNT_W(8), .PS_W(16)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .data_i    (data_i),
    .addr_i    (addr_i),
    .we_i      (we_i),
    .data_o    (data_o8),
    .int_sig_o (int_sig8),
    .int_vec_o (int_vec8)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] exp;
    string       name;
  } item_t;

  item_t sb[$];
  event  obs_ev;
  int    n_cmp = 0;
  int    n_bad = 0;

  // ---------------------------------------------------------------------------
  // Monitor: one comparison per observation event.
  // ---------------------------------------------------------------------------
  initial begin
    item_t       it;
    logic [31:0] act;
    forever begin
      @(obs_ev);
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL scoreboard_empty: observation with no expected value");
      end else begin
        it = sb.pop_front();
        case (it.kind)
          K_SIG:   act = 32'(int_sig_o);
          K_VEC:   act = 32'(int_vec_o);
          K_D8:    act = data_o8;
          default: act = data_o;
        endcase
        if (act !== it.exp) begin
          n_bad++;
          $display("FAIL %s: addr=%h got %h required %h", it.name, it.addr, act, it.exp);
        end else begin
          $display("ok   %s: addr=%h value %h", it.name, it.addr, act);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic chk(input int kind, input logic [31:0] a, input logic [31:0] e,
                     input string nm);
    item_t it;
    if (kind == K_DATA || kind == K_D8) addr_i = a;
    it.kind = kind;
    it.addr = a;
    it.exp  = e;
    it.name = nm;
    sb.push_back(it);
    #1;
    ->obs_ev;
    #1;
  endtask

  // Single-cycle write; returns 1 time unit after the write edge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    we_i   = 1'b1;
    addr_i = a;
    data_i = d;
    @(posedge clk);
    #1;
    we_i   = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst    = 1'b1;
    we_i   = 1'b0;
    addr_i = '0;
    data_i = '0;

    // Reset state
    #1;
    chk(K_DATA, 32'h00, 32'h0, "rst_ctrl");
    chk(K_DATA, 32'h04, 32'h0, "rst_count");
    chk(K_SIG,  32'h00, 32'h0, "rst_sig");
    chk(K_VEC,  32'h00, 32'h0, "rst_vec");
    @(negedge clk);
    rst = 1'b0;
    step(1);

    // One-shot, ch0, VALUE = 5: pending after enable edge + 6
    wr(32'h08, 32'd5);
    wr(32'h00, 32'h3);
    chk(K_DATA, 32'h04, 32'd0, "os_cnt_t0");
    step(1);
    chk(K_DATA, 32'h04, 32'd1, "os_cnt_t1");
    step(4);
    chk(K_DATA, 32'h04, 32'd5, "os_cnt_t5");
    chk(K_SIG,  32'h00, 32'h0, "os_sig_t5");
    step(1);
    chk(K_DATA, 32'h00, 32'h6, "os_ctrl_t6");
    chk(K_DATA, 32'h04, 32'd0, "os_cnt_t6");
    chk(K_SIG,  32'h00, 32'h1, "os_sig_t6");
    chk(K_VEC,  32'h00, 32'h1, "os_vec_t6");
    step(2);
    chk(K_DATA, 32'h04, 32'd0, "os_cnt_hold");
    chk(K_DATA, 32'h00, 32'h6, "os_ctrl_hold");
    wr(32'h00, 32'h4);
    chk(K_DATA, 32'h00, 32'h0, "os_w1c_ctrl");
    chk(K_SIG,  32'h00, 32'h0, "os_w1c_sig");

    // Periodic, ch1, VALUE = 3: period 4, five periods with W1C in between
    wr(32'h18, 32'd3);
    wr(32'h10, 32'hB);
    step(4);
    for (int k = 0; k < 5; k++) begin
      chk(K_VEC,  32'h00, 32'h2, "per_vec_set");
      chk(K_DATA, 32'h14, 32'd0, "per_cnt1");
      chk(K_DATA, 32'h04, 32'd0, "per_cnt0_idle");
      wr(32'h10, 32'hF);
      chk(K_VEC,  32'h00, 32'h0, "per_vec_clr");
      step(3);
    end
    wr(32'h10, 32'h4);
    step(1);
    chk(K_DATA, 32'h14, 32'd0, "per_off_cnt");
    chk(K_DATA, 32'h10, 32'h0, "per_off_ctrl");

    // VALUE = 0 periodic, ch0: expiry on every tick; W1C collides with it
    wr(32'h08, 32'd0);
    wr(32'h00, 32'hB);
    chk(K_VEC,  32'h00, 32'h0, "v0_vec_t0");
    step(1);
    chk(K_VEC,  32'h00, 32'h1, "v0_vec_t1");
    chk(K_DATA, 32'h04, 32'd0, "v0_cnt_t1");
    wr(32'h00, 32'hF);
    chk(K_DATA, 32'h00, 32'hF, "v0_w1c_collide");
    wr(32'h00, 32'h4);
    chk(K_DATA, 32'h00, 32'h4, "v0_disable_collide");
    chk(K_SIG,  32'h00, 32'h0, "v0_disable_sig");
    wr(32'h00, 32'h4);
    chk(K_DATA, 32'h00, 32'h0, "v0_clr");

    // One-shot collision, ch1 VALUE = 2: enable=1 written at the expiry edge
    wr(32'h18, 32'd2);
    wr(32'h10, 32'h3);
    step(2);
    wr(32'h10, 32'h7);
    chk(K_DATA, 32'h10, 32'h7, "osc_ctrl");
    chk(K_DATA, 32'h14, 32'd0, "osc_cnt");
    step(3);
    chk(K_DATA, 32'h10, 32'h6, "osc_ctrl_end");
    wr(32'h10, 32'h4);
    chk(K_DATA, 32'h10, 32'h0, "osc_clr");

    // VALUE written below COUNT, ch0
    wr(32'h08, 32'd100);
    wr(32'h00, 32'h3);
    step(10);
    chk(K_DATA, 32'h04, 32'd10, "lo_cnt10");
    wr(32'h08, 32'd2);
    chk(K_DATA, 32'h04, 32'd11, "lo_cnt11");
    chk(K_DATA, 32'h00, 32'h3,  "lo_ctrl_pre");
    step(1);
    chk(K_DATA, 32'h04, 32'd0,  "lo_cnt0");
    chk(K_DATA, 32'h00, 32'h6,  "lo_ctrl");
    wr(32'h00, 32'h4);

    // Narrow registers and upper CTRL bits
    wr(32'h08, 32'hFFFF_FFFF);
    chk(K_D8,   32'h08, 32'h0000_00FF, "w8_value");
    chk(K_DATA, 32'h08, 32'hFFFF_FFFF, "w32_value");
    chk(K_D8,   32'h18, 32'h0,         "w8_chan_oob");
    wr(32'h10, 32'hFFFF_FFF0);
    chk(K_DATA, 32'h10, 32'h0, "ctrl_upper_bits");

    // Writes to channel NUM_CH are ignored
    wr(32'h28, 32'h55);
    wr(32'h20, 32'h3);
    chk(K_DATA, 32'h28, 32'h0,         "oob_value");
    chk(K_DATA, 32'h20, 32'h0,         "oob_ctrl");
    chk(K_SIG,  32'h00, 32'h0,         "oob_sig");
    chk(K_DATA, 32'h08, 32'hFFFF_FFFF, "oob_ch0_value");
    step(1);
    chk(K_DATA, 32'h04, 32'd0, "oob_ch0_cnt");
    chk(K_DATA, 32'h14, 32'd0, "oob_ch1_cnt");
    chk(K_DATA, 32'h02, 32'h0, "unmapped_off");
    chk(K_DATA, 32'h18, 32'd2, "oob_ch1_value");

`ifdef TIMER_PRESCALER_EN
    // PRESC = 2, VALUE = 1: expiry every 6 cycles
    wr(32'h0C, 32'd2);
    chk(K_DATA, 32'h0C, 32'd2, "presc_rw");
    wr(32'h08, 32'd1);
    wr(32'h00, 32'hB);
    step(5);
    chk(K_VEC, 32'h00, 32'h0, "presc_vec_t5");
    step(1);
    chk(K_VEC, 32'h00, 32'h1, "presc_vec_t6");
    wr(32'h00, 32'hF);
    chk(K_VEC, 32'h00, 32'h0, "presc_vec_clr");
    step(4);
    chk(K_VEC, 32'h00, 32'h0, "presc_vec_t11");
    step(1);
    chk(K_VEC, 32'h00, 32'h1, "presc_vec_t12");
`else
    // No prescaler: 0xC reads 0, VALUE = 1 gives period 2
    wr(32'h0C, 32'd7);
    chk(K_DATA, 32'h0C, 32'd0, "presc_absent");
    wr(32'h08, 32'd1);
    wr(32'h00, 32'hB);
    step(1);
    chk(K_VEC,  32'h00, 32'h0, "nops_vec_t1");
    chk(K_DATA, 32'h04, 32'd1, "nops_cnt_t1");
    step(1);
    chk(K_VEC,  32'h00, 32'h1, "nops_vec_t2");
    chk(K_DATA, 32'h04, 32'd0, "nops_cnt_t2");
    wr(32'h00, 32'hF);
    chk(K_VEC,  32'h00, 32'h0, "nops_vec_clr");
    step(1);
    chk(K_VEC,  32'h00, 32'h1, "nops_vec_t4");
`endif

    // Asynchronous reset between edges, with channels running
    wr(32'h10, 32'hB);
    chk(K_SIG, 32'h00, 32'h1, "pre_rst_sig");
    @(negedge clk);
    #1;
    rst = 1'b1;
    chk(K_SIG,  32'h00, 32'h0, "arst_sig");
    chk(K_VEC,  32'h00, 32'h0, "arst_vec");
    chk(K_DATA, 32'h00, 32'h0, "arst_ctrl0");
    chk(K_DATA, 32'h14, 32'h0, "arst_cnt1");
    @(negedge clk);
    rst = 1'b0;
    step(12);
    chk(K_SIG,  32'h00, 32'h0, "post_rst_sig");
    chk(K_VEC,  32'h00, 32'h0, "post_rst_vec");
    chk(K_DATA, 32'h00, 32'h0, "post_rst_ctrl0");
    chk(K_DATA, 32'h14, 32'h0, "post_rst_cnt1");

    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: %0d left, required 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multi_timer.md
# multi_timer

Parametrised multi-channel count-up timer peripheral; successor to the single 32-bit timer on the peripheral bus. Provides NUM_CH independent channels of CNT_W bits, each with one-shot or periodic mode, an optional clock prescaler, and a write-1-to-clear interrupt pending bit. Sits on the same simple peripheral bus slot: single-cycle writes and combinational reads. Drives one OR-reduced interrupt line to the core plus a per-channel vector.

## Interface
- NUM_CH, 2: channel count, legal 1..16.
- CNT_W, 32: counter and compare width, legal 8..32.
- PS_W, 16: prescaler width, legal 1..16; used only with the prescaler macro.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- data_i  in  32  write data.
- addr_i  in  32  byte address; [7:4] = channel, [3:0] = register offset.
- we_i  in  1  write strobe, one write per asserted cycle.
- data_o  out  32  combinational read data.
- int_sig_o  out  1  OR over all channels of (pending & int_en).
- int_vec_o  out  NUM_CH  per-channel (pending & int_en).

## Operation
- Per-channel registers:
  - CTRL 0x0: [0] enable; [1] int_en; [2] pending, W1C; [3] mode, 0 = one-shot, 1 = periodic. Other bits read 0.
  - COUNT 0x4: read-only.
  - VALUE 0x8: compare value, CNT_W bits.
  - PRESC 0xC: PS_W bits.
- Channel field ≥ NUM_CH: read returns 0; write is ignored. Unmapped offsets read 0.
- Narrow registers: bits above CNT_W or PS_W are ignored on write and read 0.
- Tick: a one-cycle enable to the counter. Without the prescaler it is asserted every enabled cycle.
- Counting: on each tick while enable = 1, COUNT increments.
- Expiry: on a tick with COUNT ≥ VALUE:
  - COUNT is set to 0 and pending is set to 1.
  - In one-shot mode enable is cleared; in periodic mode the channel keeps running.
- Disabled channel: enable = 0 forces COUNT and the prescaler counter to 0 on the next edge.
- VALUE = 0: every tick expires.
- VALUE written below the current COUNT: expires on the next tick because of the ≥ compare; no wrap through 2^CNT_W.
- CTRL write in the same cycle as an expiry:
  - enable, int_en and mode take the written values.
  - Expiry setting pending dominates a W1C clear.
  - In one-shot mode the expiry's enable clear is overridden by a written enable = 1.
- Writes to other channels never affect this channel.

## Timing
- Reset value: all registers 0, data_o = 0 while rst is high, int_sig_o = 0, int_vec_o = 0.
- Reset applied mid-count aborts all channels immediately; no expiry is reported.
- Enable written at edge t, PRESC = 0, VALUE = V:
  - COUNT = 1 after edge t+1.
  - Expiry is detected in the cycle where COUNT = V; pending is visible after edge t+V+1.
  - Periodic period is V+1 cycles.
- With PRESC = P: tick every P+1 cycles, period (V+1)(P+1).
- int_sig_o and int_vec_o follow pending & int_en combinationally, with zero added latency.
- data_o is combinational from addr_i, with zero-cycle read latency.

## Configuration
- TIMER_PRESCALER_EN defined:
  - Each channel has a PS_W-bit prescaler counter.
  - The channel ticks when the prescaler counter equals PRESC; the prescaler counter then returns to 0.
  - PRESC is read/write.
- Undefined:
  - No prescaler logic is built; tick = enable.
  - Offset 0xC reads 0 and writes to it are ignored.

## Structure
- Shared package/defines holds:
  - register offsets CTRL/COUNT/VALUE/PRESC;
  - CTRL bit indices EN, IE, PEND, MODE;
  - mode encodings ONESHOT/PERIODIC;
  - existing INT_ASSERT/INT_DEASSERT, ZeroWord and WriteEnable.
- One sub-module, multi_timer_chan: one channel's registers, prescaler, counter and expiry logic. It takes a decoded per-channel write strobe and offset, and returns read data and an irq bit.
- Top level (multi_timer): instantiates NUM_CH channels via generate, does the address decode and read mux, and OR-reduces the interrupts.

## Test plan
- One-shot, ch0: VALUE = 5, CTRL = 0x3 → pending after 6 cycles, int_sig_o = 1, enable reads 0, COUNT holds 0; write CTRL = 0x4 → pending and int_sig_o clear next cycle.
- Periodic, ch1: VALUE = 3, CTRL = 0xB → int_vec_o[1] re-asserts after every W1C; expiries every 4 cycles for 5 periods; ch0 COUNT stays 0.
- Boundary: VALUE = 0 periodic → expiry every cycle. Write VALUE = 2 while COUNT = 10 → expiry next cycle, COUNT = 0. CNT_W = 8 with VALUE = 0xFFFF_FFFF → reads 0xFF.
- Collision: W1C of pending in the exact expiry cycle → pending stays 1. Write to channel NUM_CH → no state change, reads 0.
- Prescaler (macro on): PRESC = 2, VALUE = 1 → expiry every 6 cycles. Macro off → 0xC reads 0 and the period is 2.
- Async reset asserted mid-count between clock edges → all outputs 0 immediately; no interrupt after release.
